// File: rtl/blinds_position_controller.sv
// Multi-channel blind controller: manual/auto targets, override hold, dead time on reversal.
// Latency: request -> motor output after the second edge; no backpressure, requests sampled every cycle.
module blinds_position_controller #(
    parameter int N_CH     = 4,
    parameter int LIGHT_W  = 8,
    parameter int POS_MAX  = 100,
    parameter int STEP_DIV = 16,
    parameter int OVR_HOLD = 1024,
    parameter int DEAD_CYC = 8,
    localparam int POS_W   = $clog2(POS_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         auto_en,
    input  logic [N_CH*LIGHT_W-1:0] light_level,
    input  logic [LIGHT_W-1:0]      open_thr,
    input  logic [LIGHT_W-1:0]      close_thr,
    input  logic [N_CH-1:0]         open_signal,
    input  logic [N_CH-1:0]         close_signal,
    output logic [N_CH-1:0]         motor_up,
    output logic [N_CH-1:0]         motor_down,
    output logic [N_CH*POS_W-1:0]   position,
    output logic [N_CH-1:0]         blinds_open,
    output logic [N_CH-1:0]         blinds_closed,
    output logic [N_CH-1:0]         override_active,
    output logic                    cfg_err
);

    localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DEAD_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam int OVR_W  = $clog2(OVR_HOLD + 1);

    localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(POS_MAX);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYC - 1);
    localparam logic [OVR_W-1:0]  OVR_LOAD  = OVR_W'(OVR_HOLD);

    typedef enum logic [1:0] {S_IDLE, S_MOVE_UP, S_MOVE_DOWN, S_DEAD} state_t;
    typedef enum logic [1:0] {T_HOLD, T_OPEN, T_CLOSED} tgt_t;

    state_t              r_state [N_CH];
    tgt_t                r_tgt   [N_CH];
    logic [POS_W-1:0]    r_pos   [N_CH];
    logic [PRE_W-1:0]    r_pre   [N_CH];
    logic [DEAD_W-1:0]   r_dead  [N_CH];
    logic [OVR_W-1:0]    r_ovr   [N_CH];
    logic [N_CH-1:0]     r_up;
    logic [N_CH-1:0]     r_dn;
    logic                r_cfg_err;

    logic [LIGHT_W-1:0]  w_light [N_CH];
    logic                w_cfg_err;

    assign w_cfg_err = (close_thr >= open_thr);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign w_light[g]                 = light_level[g*LIGHT_W +: LIGHT_W];
        assign position[g*POS_W +: POS_W] = r_pos[g];
        assign blinds_open[g]             = (r_pos[g] == POS_TOP);
        assign blinds_closed[g]           = (r_pos[g] == '0);
        assign override_active[g]         = (r_ovr[g] != '0);
    end

    assign motor_up   = r_up;
    assign motor_down = r_dn;
    assign cfg_err    = r_cfg_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_err <= 1'b0;
            r_up      <= '0;
            r_dn      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_tgt[i]   <= T_HOLD;
                r_pos[i]   <= '0;
                r_pre[i]   <= '0;
                r_dead[i]  <= '0;
                r_ovr[i]   <= '0;
            end
        end else begin
            r_cfg_err <= w_cfg_err;
            for (int i = 0; i < N_CH; i++) begin
                // Manual requests win over auto and re-arm the override hold.
                if (open_signal[i] || close_signal[i]) begin
                    r_ovr[i] <= OVR_LOAD;
                    if (open_signal[i] && close_signal[i])
                        r_tgt[i] <= T_HOLD;
                    else if (open_signal[i])
                        r_tgt[i] <= T_OPEN;
                    else
                        r_tgt[i] <= T_CLOSED;
                end else begin
                    if (r_ovr[i] != '0)
                        r_ovr[i] <= r_ovr[i] - OVR_W'(1);
                    if (auto_en[i] && (r_ovr[i] == '0) && !w_cfg_err) begin
                        if (w_light[i] > open_thr)
                            r_tgt[i] <= T_OPEN;
                        else if (w_light[i] < close_thr)
                            r_tgt[i] <= T_CLOSED;
                    end
                end

                case (r_state[i])
                    S_IDLE: begin
                        if (r_tgt[i] == T_OPEN && r_pos[i] != POS_TOP) begin
                            r_state[i] <= S_MOVE_UP;
                            r_pre[i]   <= '0;
                            r_up[i]    <= 1'b1;
                        end else if (r_tgt[i] == T_CLOSED && r_pos[i] != '0) begin
                            r_state[i] <= S_MOVE_DOWN;
                            r_pre[i]   <= '0;
                            r_dn[i]    <= 1'b1;
                        end
                    end
                    S_MOVE_UP: begin
                        if (r_tgt[i] == T_CLOSED) begin
                            r_state[i] <= S_DEAD;
                            r_dead[i]  <= '0;
                            r_up[i]    <= 1'b0;
                        end else if (r_tgt[i] == T_HOLD || r_pos[i] == POS_TOP) begin
                            r_state[i] <= S_IDLE;
                            r_up[i]    <= 1'b0;
                        end else if (r_pre[i] == PRE_LAST) begin
                            r_pre[i] <= '0;
                            r_pos[i] <= r_pos[i] + POS_W'(1);
                            // Stop on the same edge the end position is reached.
                            if (r_pos[i] == POS_TOP - POS_W'(1)) begin
                                r_state[i] <= S_IDLE;
                                r_up[i]    <= 1'b0;
                            end
                        end else begin
                            r_pre[i] <= r_pre[i] + PRE_W'(1);
                        end
                    end
                    S_MOVE_DOWN: begin
                        if (r_tgt[i] == T_OPEN) begin
                            r_state[i] <= S_DEAD;
                            r_dead[i]  <= '0;
                            r_dn[i]    <= 1'b0;
                        end else if (r_tgt[i] == T_HOLD || r_pos[i] == '0) begin
                            r_state[i] <= S_IDLE;
                            r_dn[i]    <= 1'b0;
                        end else if (r_pre[i] == PRE_LAST) begin
                            r_pre[i] <= '0;
                            r_pos[i] <= r_pos[i] - POS_W'(1);
                            if (r_pos[i] == POS_W'(1)) begin
                                r_state[i] <= S_IDLE;
                                r_dn[i]    <= 1'b0;
                            end
                        end else begin
                            r_pre[i] <= r_pre[i] + PRE_W'(1);
                        end
                    end
                    S_DEAD: begin
                        if (r_dead[i] != DEAD_LAST) begin
                            r_dead[i] <= r_dead[i] + DEAD_W'(1);
                        end else if (r_tgt[i] == T_OPEN && r_pos[i] != POS_TOP) begin
                            r_state[i] <= S_MOVE_UP;
                            r_pre[i]   <= '0;
                            r_up[i]    <= 1'b1;
                        end else if (r_tgt[i] == T_CLOSED && r_pos[i] != '0) begin
                            r_state[i] <= S_MOVE_DOWN;
                            r_pre[i]   <= '0;
                            r_dn[i]    <= 1'b1;
                        end else begin
                            r_state[i] <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state[i] <= S_IDLE;
                        r_up[i]    <= 1'b0;
                        r_dn[i]    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blinds_position_controller.sv
// Directed bench for blinds_position_controller with a 2-channel, short-travel configuration.
module tb_blinds_position_controller;

    localparam int N_CH = 2;
    localparam int LW   = 8;
    localparam int PW   = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_CH-1:0]   auto_en = '0;
    logic [N_CH*LW-1:0] light_level = '0;
    logic [LW-1:0]     open_thr = 8'd150;
    logic [LW-1:0]     close_thr = 8'd100;
    logic [N_CH-1:0]   open_signal = '0;
    logic [N_CH-1:0]   close_signal = '0;
    logic [N_CH-1:0]   motor_up;
    logic [N_CH-1:0]   motor_down;
    logic [N_CH*PW-1:0] position;
    logic [N_CH-1:0]   blinds_open;
    logic [N_CH-1:0]   blinds_closed;
    logic [N_CH-1:0]   override_active;
    logic              cfg_err;

    always #5 clk = ~clk;

    blinds_position_controller #(
        .N_CH(2), .LIGHT_W(8), .POS_MAX(4), .STEP_DIV(2), .OVR_HOLD(8), .DEAD_CYC(2)
    ) dut (
        .clk(clk), .rst(rst), .auto_en(auto_en), .light_level(light_level),
        .open_thr(open_thr), .close_thr(close_thr),
        .open_signal(open_signal), .close_signal(close_signal),
        .motor_up(motor_up), .motor_down(motor_down), .position(position),
        .blinds_open(blinds_open), .blinds_closed(blinds_closed),
        .override_active(override_active), .cfg_err(cfg_err)
    );

    // Expected bundle: {up, dn, pos0, pos1, open, closed, ovr, cfg}
    typedef struct {
        int          n;
        logic [1:0]  op;
        logic [1:0]  cl;
        logic [1:0]  au;
        logic [7:0]  l0;
        logic [7:0]  l1;
        logic [7:0]  ot;
        logic [7:0]  ct;
        logic [16:0] exp;
    } vec_t;

    vec_t vt [38];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int n, logic [1:0] op, logic [1:0] cl, logic [1:0] au,
                                int l0, int l1, int ot, int ct,
                                logic [1:0] up, logic [1:0] dn, int p0, int p1,
                                logic [1:0] bop, logic [1:0] bcl, logic [1:0] ovr, logic cfg);
        vec_t v;
        v.n   = n;
        v.op  = op;
        v.cl  = cl;
        v.au  = au;
        v.l0  = 8'(l0);
        v.l1  = 8'(l1);
        v.ot  = 8'(ot);
        v.ct  = 8'(ct);
        v.exp = {up, dn, 3'(p0), 3'(p1), bop, bcl, ovr, cfg};
        return v;
    endfunction

    function automatic logic [16:0] obs();
        return {motor_up, motor_down, position[2:0], position[5:3],
                blinds_open, blinds_closed, override_active, cfg_err};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] got;
        got = obs();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got up=%b dn=%b pos=%0d/%0d open=%b closed=%b ovr=%b cfg=%b, want up=%b dn=%b pos=%0d/%0d open=%b closed=%b ovr=%b cfg=%b",
                     name, got[16:15], got[14:13], got[12:10], got[9:7], got[6:5], got[4:3], got[2:1], got[0],
                     exp[16:15], exp[14:13], exp[12:10], exp[9:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge; motors must never both drive.
    task automatic tick();
        @(posedge clk);
        #1;
        n_chk++;
        if ((motor_up & motor_down) != '0) begin
            n_fail++;
            $display("FAIL motor_overlap: up=%b dn=%b at %0t, want no common bit", motor_up, motor_down, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        open_signal  = v.op;
        close_signal = v.cl;
        auto_en      = v.au;
        light_level  = {v.l1, v.l0};
        open_thr     = v.ot;
        close_thr    = v.ct;
    endtask

    localparam logic [16:0] RST_EXP = {2'b00, 2'b00, 3'd0, 3'd0, 2'b00, 2'b11, 2'b00, 1'b0};

    initial begin
        //            n  op     cl     au     l0   l1   ot   ct   up     dn     p0 p1 bop    bcl    ovr    cfg
        vt[0]  = mk(1, 2'b01, 2'b00, 2'b00,   0,   0, 150, 100, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 2'b01, 0);
        vt[1]  = mk(1, 2'b00, 2'b00, 2'b00,   0,   0, 150, 100, 2'b01, 2'b00, 0, 0, 2'b00, 2'b11, 2'b01, 0);
        vt[2]  = mk(2, 2'b00, 2'b00, 2'b00,   0,   0, 150, 100, 2'b01, 2'b00, 1, 0, 2'b00, 2'b10, 2'b01, 0);
        vt[3]  = mk(5, 2'b00, 2'b00, 2'b00,   0,   0, 150, 100, 2'b01, 2'b00, 3, 0, 2'b00, 2'b10, 2'b00, 0);
        vt[4]  = mk(1, 2'b00, 2'b00, 2'b00,   0,   0, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[5]  = mk(1, 2'b00, 2'b00, 2'b01,  90,   0, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[6]  = mk(1, 2'b00, 2'b00, 2'b01,  90,   0, 150, 100, 2'b00, 2'b01, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[7]  = mk(2, 2'b00, 2'b00, 2'b01,  90,   0, 150, 100, 2'b00, 2'b01, 3, 0, 2'b00, 2'b10, 2'b00, 0);
        vt[8]  = mk(5, 2'b00, 2'b00, 2'b01,  90,   0, 150, 100, 2'b00, 2'b01, 1, 0, 2'b00, 2'b10, 2'b00, 0);
        vt[9]  = mk(1, 2'b00, 2'b00, 2'b01,  90,   0, 150, 100, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        vt[10] = mk(4, 2'b00, 2'b00, 2'b01, 120,   0, 150, 100, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        vt[11] = mk(1, 2'b00, 2'b00, 2'b01, 160,   0, 150, 100, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        vt[12] = mk(1, 2'b00, 2'b00, 2'b01, 160,   0, 150, 100, 2'b01, 2'b00, 0, 0, 2'b00, 2'b11, 2'b00, 0);
        vt[13] = mk(8, 2'b00, 2'b00, 2'b01, 160,   0, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[14] = mk(1, 2'b00, 2'b10, 2'b11, 200, 200, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b10, 0);
        vt[15] = mk(7, 2'b00, 2'b00, 2'b11, 200, 200, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b10, 0);
        vt[16] = mk(1, 2'b00, 2'b00, 2'b11, 200, 200, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[17] = mk(1, 2'b00, 2'b00, 2'b11, 200, 200, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[18] = mk(1, 2'b00, 2'b00, 2'b11, 200, 200, 150, 100, 2'b10, 2'b00, 4, 0, 2'b01, 2'b10, 2'b00, 0);
        vt[19] = mk(2, 2'b00, 2'b00, 2'b11, 200, 200, 150, 100, 2'b10, 2'b00, 4, 1, 2'b01, 2'b00, 2'b00, 0);
        vt[20] = mk(2, 2'b00, 2'b00, 2'b11, 200, 200, 150, 100, 2'b10, 2'b00, 4, 2, 2'b01, 2'b00, 2'b00, 0);
        vt[21] = mk(1, 2'b00, 2'b10, 2'b00, 200, 200, 150, 100, 2'b10, 2'b00, 4, 2, 2'b01, 2'b00, 2'b10, 0);
        vt[22] = mk(1, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b00, 4, 2, 2'b01, 2'b00, 2'b10, 0);
        vt[23] = mk(1, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b00, 4, 2, 2'b01, 2'b00, 2'b10, 0);
        vt[24] = mk(1, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b10, 4, 2, 2'b01, 2'b00, 2'b10, 0);
        vt[25] = mk(2, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b10, 4, 1, 2'b01, 2'b00, 2'b10, 0);
        vt[26] = mk(2, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b10, 0);
        vt[27] = mk(1, 2'b10, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b00, 4, 0, 2'b01, 2'b10, 2'b10, 0);
        vt[28] = mk(1, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b10, 2'b00, 4, 0, 2'b01, 2'b10, 2'b10, 0);
        vt[29] = mk(2, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b10, 2'b00, 4, 1, 2'b01, 2'b00, 2'b10, 0);
        vt[30] = mk(1, 2'b10, 2'b10, 2'b00, 200, 200, 150, 100, 2'b10, 2'b00, 4, 1, 2'b01, 2'b00, 2'b10, 0);
        vt[31] = mk(1, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b00, 4, 1, 2'b01, 2'b00, 2'b10, 0);
        vt[32] = mk(3, 2'b00, 2'b00, 2'b00, 200, 200, 150, 100, 2'b00, 2'b00, 4, 1, 2'b01, 2'b00, 2'b10, 0);
        vt[33] = mk(4, 2'b00, 2'b00, 2'b11,  50, 200, 100, 150, 2'b00, 2'b00, 4, 1, 2'b01, 2'b00, 2'b00, 1);
        vt[34] = mk(6, 2'b00, 2'b00, 2'b11,  50, 200, 100, 150, 2'b00, 2'b00, 4, 1, 2'b01, 2'b00, 2'b00, 1);
        vt[35] = mk(1, 2'b00, 2'b01, 2'b11,  50, 200, 150, 100, 2'b00, 2'b00, 4, 1, 2'b01, 2'b00, 2'b01, 0);
        vt[36] = mk(1, 2'b00, 2'b00, 2'b11,  50, 200, 150, 100, 2'b10, 2'b01, 4, 1, 2'b01, 2'b00, 2'b01, 0);
        vt[37] = mk(2, 2'b00, 2'b00, 2'b11,  50, 200, 150, 100, 2'b10, 2'b01, 3, 2, 2'b00, 2'b00, 2'b01, 0);

        #1 rst = 1'b0;
        #2;
        check("reset_values", RST_EXP);
        tick();
        tick();
        check("reset_held", RST_EXP);
        rst = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", RST_EXP);

        for (int j = 0; j < 38; j++) begin
            drive(vt[j]);
            for (int k = 0; k < vt[j].n; k++) tick();
            check($sformatf("vec%0d", j), vt[j].exp);
        end

        // Both channels are moving here; reset must drop everything at once.
        #2 rst = 1'b0;
        #1;
        check("reset_mid_motion", RST_EXP);
        open_signal  = '0;
        close_signal = '0;
        auto_en      = '0;
        light_level  = '0;
        tick();
        tick();
        check("reset_mid_held", RST_EXP);
        rst = 1'b1;
        repeat (6) tick();
        check("after_release_idle", RST_EXP);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
